// File: rtl/axi_wr_route_ctrl.sv
// axi_wr_route_ctrl: write-channel routing controller for a 1-master /
// 2-slave AXI path. AW addresses are decoded to a slave index and recorded
// in a circular route queue. W beats and B responses are steered in AW order
// from that queue.
//
// Optional feature macro: AXI_WR_ROUTE_DECERR_EN
//   defined   - unmatched addresses get route code 2; the block sinks their W
//               beats and answers their B with DECERR (2'b11).
//   undefined - unmatched addresses route to slave 0 (1-bit route entries).
//
// Handshake semantics (all channels): a transfer happens on a rising ACLK
// edge where VALID and READY are both 1. Once VALID is raised, the source
// holds it and its payload until the transfer. READY may depend
// combinationally on VALID and on the route, but VALID never depends on READY.
//
// dbg_out_cnt / dbg_w_pend expose the queue occupancy counters for checkers.
module axi_wr_route_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] S0_BASE    = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] S0_MASK    = 32'hF000_0000,
  parameter logic [ADDR_WIDTH-1:0] S1_BASE    = 32'h1000_0000,
  parameter logic [ADDR_WIDTH-1:0] S1_MASK    = 32'hF000_0000,
  parameter int                    DEPTH      = 4
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  // master AW
  input  logic [ADDR_WIDTH-1:0]     S_AWADDR,
  input  logic                      S_AWVALID,
  output logic                      S_AWREADY,
  // master W
  input  logic [DATA_WIDTH-1:0]     S_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   S_WSTRB,
  input  logic                      S_WLAST,
  input  logic                      S_WVALID,
  output logic                      S_WREADY,
  // master B
  output logic [1:0]                S_BRESP,
  output logic                      S_BVALID,
  input  logic                      S_BREADY,
  // slave 0
  output logic [ADDR_WIDTH-1:0]     M0_AWADDR,
  output logic                      M0_AWVALID,
  input  logic                      M0_AWREADY,
  output logic [DATA_WIDTH-1:0]     M0_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M0_WSTRB,
  output logic                      M0_WLAST,
  output logic                      M0_WVALID,
  input  logic                      M0_WREADY,
  input  logic [1:0]                M0_BRESP,
  input  logic                      M0_BVALID,
  output logic                      M0_BREADY,
  // slave 1
  output logic [ADDR_WIDTH-1:0]     M1_AWADDR,
  output logic                      M1_AWVALID,
  input  logic                      M1_AWREADY,
  output logic [DATA_WIDTH-1:0]     M1_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M1_WSTRB,
  output logic                      M1_WLAST,
  output logic                      M1_WVALID,
  input  logic                      M1_WREADY,
  input  logic [1:0]                M1_BRESP,
  input  logic                      M1_BVALID,
  output logic                      M1_BREADY,
  // queue occupancy
  output logic [$clog2(DEPTH):0]    dbg_out_cnt,
  output logic [$clog2(DEPTH):0]    dbg_w_pend
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
`ifdef AXI_WR_ROUTE_DECERR_EN
  localparam int RW = 2;
`else
  localparam int RW = 1;
`endif

  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [PW:0]   wp, wh, bh;
  logic [PW:0]   out_cnt, w_pend;
  logic [RW-1:0] route_q [DEPTH];
  logic [RW-1:0] sel, w_route, b_route;
  logic          s0_hit, s1_hit;
  logic          aw_to0, aw_to1, aw_toe;
  logic          w_to0, w_to1, w_toe;
  logic          b_to0, b_to1, b_toe;
  logic          live, aw_ok, w_act, b_act;
  logic          aw_hs, w_last_hs, b_hs;

  assign out_cnt     = wp - bh;
  assign w_pend      = wp - wh;
  assign dbg_out_cnt = out_cnt;
  assign dbg_w_pend  = w_pend;
  assign w_route     = route_q[wh[PW-1:0]];
  assign b_route     = route_q[bh[PW-1:0]];

  // Outputs are forced idle while reset is held.
  assign live  = ~ARESET;
  assign aw_ok = live & (out_cnt != FULL_CNT);
  assign w_act = live & (w_pend != '0);
  assign b_act = live & (bh != wh);

  // Address decode and one-hot route flags for the AW, W head and B head.
  always_comb begin
    s0_hit = (S_AWADDR & S0_MASK) == S0_BASE;
    s1_hit = (S_AWADDR & S1_MASK) == S1_BASE;
`ifdef AXI_WR_ROUTE_DECERR_EN
    sel    = s0_hit ? 2'd0 : (s1_hit ? 2'd1 : 2'd2);
    aw_to0 = (sel == 2'd0);
    aw_to1 = (sel == 2'd1);
    aw_toe = (sel == 2'd2);
    w_to0  = (w_route == 2'd0);
    w_to1  = (w_route == 2'd1);
    w_toe  = (w_route == 2'd2);
    b_to0  = (b_route == 2'd0);
    b_to1  = (b_route == 2'd1);
    b_toe  = (b_route == 2'd2);
`else
    sel    = (!s0_hit && s1_hit) ? 1'b1 : 1'b0;
    aw_to0 = ~sel[0];
    aw_to1 = sel[0];
    aw_toe = 1'b0;
    w_to0  = ~w_route[0];
    w_to1  = w_route[0];
    w_toe  = 1'b0;
    b_to0  = ~b_route[0];
    b_to1  = b_route[0];
    b_toe  = 1'b0;
`endif
  end

  // AW: forward to the decoded slave while the queue has room.
  assign M0_AWVALID = S_AWVALID & aw_ok & aw_to0;
  assign M1_AWVALID = S_AWVALID & aw_ok & aw_to1;
  assign M0_AWADDR  = (live & aw_to0) ? S_AWADDR : '0;
  assign M1_AWADDR  = (live & aw_to1) ? S_AWADDR : '0;
  assign S_AWREADY  = aw_ok & ((aw_to0 & M0_AWREADY) | (aw_to1 & M1_AWREADY) | aw_toe);
  assign aw_hs      = S_AWVALID & S_AWREADY;

  // W: steer to the route at the W head; stall while no AW is pending.
  assign M0_WVALID  = w_act & w_to0 & S_WVALID;
  assign M1_WVALID  = w_act & w_to1 & S_WVALID;
  assign M0_WDATA   = (w_act & w_to0) ? S_WDATA : '0;
  assign M1_WDATA   = (w_act & w_to1) ? S_WDATA : '0;
  assign M0_WSTRB   = (w_act & w_to0) ? S_WSTRB : '0;
  assign M1_WSTRB   = (w_act & w_to1) ? S_WSTRB : '0;
  assign M0_WLAST   = w_act & w_to0 & S_WLAST;
  assign M1_WLAST   = w_act & w_to1 & S_WLAST;
  assign S_WREADY   = w_act & ((w_to0 & M0_WREADY) | (w_to1 & M1_WREADY) | w_toe);
  assign w_last_hs  = S_WVALID & S_WREADY & S_WLAST;

  // B: only the B-head entry whose WLAST has been taken may respond.
  assign S_BVALID   = b_act & ((b_to0 & M0_BVALID) | (b_to1 & M1_BVALID) | b_toe);
  assign M0_BREADY  = b_act & b_to0 & S_BREADY;
  assign M1_BREADY  = b_act & b_to1 & S_BREADY;
  assign b_hs       = S_BVALID & S_BREADY;

  // B response mux; DECERR is generated locally for unmatched entries.
  always_comb begin
    S_BRESP = 2'b00;
    if (b_act) begin
      if (b_to0)      S_BRESP = M0_BRESP;
      else if (b_to1) S_BRESP = M1_BRESP;
      else if (b_toe) S_BRESP = 2'b11;
    end
  end

  // Queue pointers: push on AW, W head advances on WLAST, B head on B.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wp <= '0;
      wh <= '0;
      bh <= '0;
    end else begin
      if (aw_hs)     wp <= wp + 1'b1;
      if (w_last_hs) wh <= wh + 1'b1;
      if (b_hs)      bh <= bh + 1'b1;
    end
  end

  // Route storage; entries are only read once the pointers cover them.
  always_ff @(posedge ACLK) begin
    if (aw_hs) route_q[wp[PW-1:0]] <= sel;
  end

endmodule

// File: tb/tb_axi_wr_route_ctrl.sv
// Testbench for axi_wr_route_ctrl: scenario tasks plus a randomized run
// checked against a route queue model derived from the address map.
module tb_axi_wr_route_ctrl;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 4;
  localparam int WB    = DW + SW + 1;

  logic           ACLK, ARESET;
  logic [AW-1:0]  S_AWADDR;
  logic           S_AWVALID, S_AWREADY;
  logic [DW-1:0]  S_WDATA;
  logic [SW-1:0]  S_WSTRB;
  logic           S_WLAST, S_WVALID, S_WREADY;
  logic [1:0]     S_BRESP;
  logic           S_BVALID, S_BREADY;
  logic [AW-1:0]  M0_AWADDR, M1_AWADDR;
  logic           M0_AWVALID, M0_AWREADY, M1_AWVALID, M1_AWREADY;
  logic [DW-1:0]  M0_WDATA, M1_WDATA;
  logic [SW-1:0]  M0_WSTRB, M1_WSTRB;
  logic           M0_WLAST, M0_WVALID, M0_WREADY, M1_WLAST, M1_WVALID, M1_WREADY;
  logic [1:0]     M0_BRESP, M1_BRESP;
  logic           M0_BVALID, M0_BREADY, M1_BVALID, M1_BREADY;
  logic [2:0]     dbg_out_cnt, dbg_w_pend;

  int checks;
  int errors;
  // Routes of outstanding writes, oldest first; w_idx = entries whose WLAST is done.
  logic [1:0] exp_q[$];
  int w_idx;

  axi_wr_route_ctrl dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST),
    .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .M0_AWADDR(M0_AWADDR), .M0_AWVALID(M0_AWVALID), .M0_AWREADY(M0_AWREADY),
    .M0_WDATA(M0_WDATA), .M0_WSTRB(M0_WSTRB), .M0_WLAST(M0_WLAST),
    .M0_WVALID(M0_WVALID), .M0_WREADY(M0_WREADY),
    .M0_BRESP(M0_BRESP), .M0_BVALID(M0_BVALID), .M0_BREADY(M0_BREADY),
    .M1_AWADDR(M1_AWADDR), .M1_AWVALID(M1_AWVALID), .M1_AWREADY(M1_AWREADY),
    .M1_WDATA(M1_WDATA), .M1_WSTRB(M1_WSTRB), .M1_WLAST(M1_WLAST),
    .M1_WVALID(M1_WVALID), .M1_WREADY(M1_WREADY),
    .M1_BRESP(M1_BRESP), .M1_BVALID(M1_BVALID), .M1_BREADY(M1_BREADY),
    .dbg_out_cnt(dbg_out_cnt), .dbg_w_pend(dbg_w_pend)
  );

  // Clock and watchdog
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Address map: S0 checked first, then S1, else unmatched.
  function automatic logic [1:0] exp_route(input logic [31:0] a);
    if ((a & 32'hF000_0000) == 32'h0000_0000) return 2'd0;
    if ((a & 32'hF000_0000) == 32'h1000_0000) return 2'd1;
`ifdef AXI_WR_ROUTE_DECERR_EN
    return 2'd2;
`else
    return 2'd0;
`endif
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [3:0] top;
    case ($urandom_range(0, 2))
      0:       top = 4'h0;
      1:       top = 4'h1;
      default: top = 4'($urandom_range(2, 15));
    endcase
    return {top, 28'($urandom)};
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle_inputs();
    S_AWADDR = '0; S_AWVALID = 0; S_WDATA = '0; S_WSTRB = '0; S_WLAST = 0;
    S_WVALID = 0; S_BREADY = 0;
    M0_AWREADY = 0; M1_AWREADY = 0; M0_WREADY = 0; M1_WREADY = 0;
    M0_BRESP = '0; M1_BRESP = '0; M0_BVALID = 0; M1_BVALID = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    ARESET = 1;
    tick();
    tick();
    ARESET = 0;
    exp_q.delete();
    w_idx = 0;
  endtask

  // Driver: one AW transfer, optionally with random slave-ready stalls.
  task automatic do_aw(input logic [31:0] addr, input bit stall);
    logic [1:0] r;
    logic r0, r1, exp_rdy;
    bit done;
    r = exp_route(addr);
    done = 0;
    S_AWADDR = addr;
    S_AWVALID = 1;
    for (int t = 0; t < 30 && !done; t++) begin
      r0 = (stall && t < 10) ? 1'($urandom_range(0, 1)) : 1'b1;
      r1 = (stall && t < 10) ? 1'($urandom_range(0, 1)) : 1'b1;
      M0_AWREADY = r0;
      M1_AWREADY = r1;
      exp_rdy = (r == 2'd0) ? r0 : ((r == 2'd1) ? r1 : 1'b1);
      #1;
      checks++;
      if ({M0_AWVALID, M1_AWVALID, S_AWREADY} !== {r == 2'd0, r == 2'd1, exp_rdy}) begin
        errors++;
        $display("FAIL aw_route addr=%h got v0/v1/rdy=%b%b%b expected %b%b%b", addr,
                 M0_AWVALID, M1_AWVALID, S_AWREADY, r == 2'd0, r == 2'd1, exp_rdy);
      end
      checks++;
      if (M0_AWADDR !== ((r == 2'd0) ? addr : 32'h0) || M1_AWADDR !== ((r == 2'd1) ? addr : 32'h0)) begin
        errors++;
        $display("FAIL aw_addr addr=%h got m0=%h m1=%h", addr, M0_AWADDR, M1_AWADDR);
      end
      tick();
      done = exp_rdy;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL aw_timeout addr=%h", addr);
    end
    S_AWVALID = 0; S_AWADDR = '0; M0_AWREADY = 0; M1_AWREADY = 0;
    exp_q.push_back(r);
  endtask

  // Driver: one W burst for the oldest entry still awaiting data.
  task automatic do_w_burst(input int n, input bit stall);
    logic [1:0]    r;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic          last, r0, r1, exp_rdy, exp_bv;
    logic [WB-1:0] exp0, exp1;
    bit done;
    r = exp_q[w_idx];
    exp_bv = (w_idx > 0) && (exp_q[0] == 2'd2);
    M0_BVALID = 0; M1_BVALID = 0;
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      s = SW'($urandom);
      last = (i == n - 1);
      S_WDATA = d; S_WSTRB = s; S_WLAST = last; S_WVALID = 1;
      exp0 = (r == 2'd0) ? {d, s, last} : '0;
      exp1 = (r == 2'd1) ? {d, s, last} : '0;
      done = 0;
      for (int t = 0; t < 30 && !done; t++) begin
        r0 = (stall && t < 10) ? 1'($urandom_range(0, 1)) : 1'b1;
        r1 = (stall && t < 10) ? 1'($urandom_range(0, 1)) : 1'b1;
        M0_WREADY = r0;
        M1_WREADY = r1;
        exp_rdy = (r == 2'd0) ? r0 : ((r == 2'd1) ? r1 : 1'b1);
        #1;
        checks++;
        if ({S_WREADY, M0_WVALID, M1_WVALID} !== {exp_rdy, r == 2'd0, r == 2'd1}) begin
          errors++;
          $display("FAIL w_route beat=%0d got rdy/v0/v1=%b%b%b expected %b%b%b", i,
                   S_WREADY, M0_WVALID, M1_WVALID, exp_rdy, r == 2'd0, r == 2'd1);
        end
        checks++;
        if ({M0_WDATA, M0_WSTRB, M0_WLAST} !== exp0 || {M1_WDATA, M1_WSTRB, M1_WLAST} !== exp1) begin
          errors++;
          $display("FAIL w_payload beat=%0d got m0=%h m1=%h expected m0=%h m1=%h", i,
                   {M0_WDATA, M0_WSTRB, M0_WLAST}, {M1_WDATA, M1_WSTRB, M1_WLAST}, exp0, exp1);
        end
        checks++;
        if (S_BVALID !== exp_bv) begin
          errors++;
          $display("FAIL w_bvalid beat=%0d got %b expected %b", i, S_BVALID, exp_bv);
        end
        tick();
        done = exp_rdy;
      end
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL w_timeout beat=%0d", i);
      end
    end
    S_WVALID = 0; S_WLAST = 0; S_WDATA = '0; S_WSTRB = '0; M0_WREADY = 0; M1_WREADY = 0;
    w_idx++;
  endtask

  // Driver: one B transfer for the oldest entry; the other slave toggles BVALID.
  task automatic do_b(input bit stall);
    logic [1:0] r, resp0, resp1, exp_resp;
    logic vr, bv0, bv1, br, exp_v;
    bit done;
    r = exp_q[0];
    done = 0;
    for (int t = 0; t < 30 && !done; t++) begin
      vr = (stall && t < 10) ? 1'($urandom_range(0, 1)) : 1'b1;
      br = (stall && t < 10) ? 1'($urandom_range(0, 1)) : 1'b1;
      bv0 = (r == 2'd0) ? vr : 1'($urandom_range(0, 1));
      bv1 = (r == 2'd1) ? vr : 1'($urandom_range(0, 1));
      resp0 = 2'($urandom);
      resp1 = 2'($urandom);
      M0_BVALID = bv0; M1_BVALID = bv1; M0_BRESP = resp0; M1_BRESP = resp1; S_BREADY = br;
      exp_v = (r == 2'd0) ? bv0 : ((r == 2'd1) ? bv1 : 1'b1);
      exp_resp = (r == 2'd0) ? resp0 : ((r == 2'd1) ? resp1 : 2'b11);
      #1;
      checks++;
      if (S_BVALID !== exp_v) begin
        errors++;
        $display("FAIL b_valid route=%0d got %b expected %b", r, S_BVALID, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (S_BRESP !== exp_resp) begin
          errors++;
          $display("FAIL b_resp route=%0d got %b expected %b", r, S_BRESP, exp_resp);
        end
      end
      checks++;
      if ({M0_BREADY, M1_BREADY} !== {(r == 2'd0) && br, (r == 2'd1) && br}) begin
        errors++;
        $display("FAIL b_ready route=%0d got %b%b", r, M0_BREADY, M1_BREADY);
      end
      tick();
      done = exp_v && br;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL b_timeout route=%0d", r);
    end
    M0_BVALID = 0; M1_BVALID = 0; S_BREADY = 0; M0_BRESP = '0; M1_BRESP = '0;
    void'(exp_q.pop_front());
    w_idx--;
  endtask

  task automatic drain();
    while (w_idx < exp_q.size()) do_w_burst($urandom_range(1, 3), 0);
    while (exp_q.size() > 0) do_b(0);
    checks++;
    if (dbg_out_cnt !== 3'd0) begin
      errors++;
      $display("FAIL drain_out_cnt got %0d expected 0", dbg_out_cnt);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    ARESET = 1;
    S_AWVALID = 1; S_WVALID = 1; S_BREADY = 1; M0_AWREADY = 1; M1_AWREADY = 1;
    M0_WREADY = 1; M1_WREADY = 1; M0_BVALID = 1; M1_BVALID = 1; M0_BRESP = 2'b01;
    S_AWADDR = 32'h1000_0004; S_WDATA = 32'hDEAD_BEEF;
    tick();
    tick();
    checks++;
    if ({S_AWREADY, S_WREADY, S_BVALID, M0_AWVALID, M1_AWVALID, M0_WVALID, M1_WVALID,
         M0_BREADY, M1_BREADY} !== 9'b0) begin
      errors++;
      $display("FAIL reset_handshakes got %b expected 0", {S_AWREADY, S_WREADY, S_BVALID,
               M0_AWVALID, M1_AWVALID, M0_WVALID, M1_WVALID, M0_BREADY, M1_BREADY});
    end
    checks++;
    if ((M0_AWADDR | M1_AWADDR | M0_WDATA | M1_WDATA) !== 32'h0 || S_BRESP !== 2'b00) begin
      errors++;
      $display("FAIL reset_data got aw=%h/%h w=%h/%h bresp=%b", M0_AWADDR, M1_AWADDR,
               M0_WDATA, M1_WDATA, S_BRESP);
    end
    idle_inputs();
    ARESET = 0;
    #1;
    checks++;
    if (dbg_out_cnt !== 3'd0 || dbg_w_pend !== 3'd0 || S_AWREADY !== 1'b0 || S_WREADY !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got out=%0d wp=%0d awr=%b wr=%b", dbg_out_cnt, dbg_w_pend,
               S_AWREADY, S_WREADY);
    end
    tick();
  endtask

  task automatic test_single_m1();
    do_reset();
    do_aw(32'h1000_0040, 0);
    do_w_burst(4, 0);
    do_b(0);
    checks++;
    if (dbg_out_cnt !== 3'd0) begin
      errors++;
      $display("FAIL single_out_cnt got %0d expected 0", dbg_out_cnt);
    end
  endtask

  task automatic test_order();
    do_reset();
    do_aw(32'h0000_0000, 0);
    do_aw(32'h1000_0000, 0);
    do_w_burst(2, 0);
    do_w_burst(1, 0);
    M1_BVALID = 1; M1_BRESP = 2'b01; S_BREADY = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (S_BVALID !== 1'b0 || M1_BREADY !== 1'b0) begin
        errors++;
        $display("FAIL order_hold cyc=%0d got bvalid=%b m1_bready=%b expected 0 0", i, S_BVALID, M1_BREADY);
      end
      tick();
    end
    M0_BVALID = 1; M0_BRESP = 2'b10;
    #1;
    checks++;
    if ({S_BVALID, S_BRESP, M0_BREADY, M1_BREADY} !== 5'b1_10_1_0) begin
      errors++;
      $display("FAIL order_first got %b expected 11010", {S_BVALID, S_BRESP, M0_BREADY, M1_BREADY});
    end
    tick();
    M0_BVALID = 0;
    #1;
    checks++;
    if ({S_BVALID, S_BRESP, M0_BREADY, M1_BREADY} !== 5'b1_01_0_1) begin
      errors++;
      $display("FAIL order_second got %b expected 10101", {S_BVALID, S_BRESP, M0_BREADY, M1_BREADY});
    end
    tick();
    idle_inputs();
    exp_q.delete();
    w_idx = 0;
    checks++;
    if (dbg_out_cnt !== 3'd0) begin
      errors++;
      $display("FAIL order_out_cnt got %0d expected 0", dbg_out_cnt);
    end
  endtask

  task automatic test_early_w();
    do_reset();
    S_WVALID = 1; S_WLAST = 1; S_WDATA = 32'h1234_5678; S_WSTRB = 4'hF;
    M0_WREADY = 1; M1_WREADY = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({S_WREADY, M0_WVALID, M1_WVALID} !== 3'b000 || (M0_WDATA | M1_WDATA) !== 32'h0) begin
        errors++;
        $display("FAIL early_w_stall cyc=%0d got rdy/v0/v1=%b%b%b", i, S_WREADY, M0_WVALID, M1_WVALID);
      end
      tick();
    end
    S_AWADDR = 32'h1000_0080; S_AWVALID = 1; M1_AWREADY = 1;
    #1;
    checks++;
    if (S_AWREADY !== 1'b1 || S_WREADY !== 1'b0) begin
      errors++;
      $display("FAIL early_w_same_cycle got awready=%b wready=%b expected 1 0", S_AWREADY, S_WREADY);
    end
    tick();
    S_AWVALID = 0; M1_AWREADY = 0;
    exp_q.push_back(2'd1);
    do_w_burst(1, 0);
    do_b(0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    do_aw(32'h0000_0100, 0);
    do_aw(32'h1000_0200, 0);
    do_aw(32'h0000_0300, 0);
    do_w_burst(3, 0);
    do_w_burst(3, 0);
    do_w_burst(3, 0);
    drain();
  endtask

  task automatic test_full();
    logic [31:0] a5, a6;
    logic [1:0]  r;
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_aw({4'($urandom_range(0, 1)), 28'($urandom)}, 0);
    a5 = 32'h1000_0500;
    S_AWADDR = a5; S_AWVALID = 1; M0_AWREADY = 1; M1_AWREADY = 1;
    #1;
    checks++;
    if ({S_AWREADY, M0_AWVALID, M1_AWVALID} !== 3'b000 || dbg_out_cnt !== 3'd4) begin
      errors++;
      $display("FAIL full_stall got rdy/v0/v1=%b%b%b out=%0d", S_AWREADY, M0_AWVALID, M1_AWVALID, dbg_out_cnt);
    end
    tick();
    do_w_burst(2, 0);
    r = exp_q[0];
    M0_BVALID = (r == 2'd0); M1_BVALID = (r == 2'd1); S_BREADY = 1;
    #1;
    checks++;
    if (S_BVALID !== 1'b1 || dbg_out_cnt !== 3'd4) begin
      errors++;
      $display("FAIL full_b got bvalid=%b out=%0d expected 1 4", S_BVALID, dbg_out_cnt);
    end
    tick();
    M0_BVALID = 0; M1_BVALID = 0; S_BREADY = 0;
    void'(exp_q.pop_front());
    w_idx--;
    do_aw(a5, 0);
    checks++;
    if (dbg_out_cnt !== 3'd4) begin
      errors++;
      $display("FAIL full_refill got %0d expected 4", dbg_out_cnt);
    end
    do_w_burst(1, 0);
    do_b(0);
    do_w_burst(1, 0);
    a6 = 32'h0000_0600;
    r = exp_q[0];
    S_AWADDR = a6; S_AWVALID = 1; M0_AWREADY = 1; M1_AWREADY = 1;
    M0_BVALID = (r == 2'd0); M1_BVALID = (r == 2'd1); S_BREADY = 1;
    #1;
    checks++;
    if (S_AWREADY !== 1'b1 || S_BVALID !== 1'b1) begin
      errors++;
      $display("FAIL push_pop_same got awready=%b bvalid=%b expected 1 1", S_AWREADY, S_BVALID);
    end
    tick();
    idle_inputs();
    void'(exp_q.pop_front());
    w_idx--;
    exp_q.push_back(exp_route(a6));
    checks++;
    if (dbg_out_cnt !== 3'd3) begin
      errors++;
      $display("FAIL push_pop_cnt got %0d expected 3", dbg_out_cnt);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_aw(32'h0000_0040, 0);
    S_WVALID = 1; S_WDATA = 32'hA5A5_0001; S_WSTRB = 4'hF; M0_WREADY = 1;
    tick();
    S_WDATA = 32'hA5A5_0002; ARESET = 1;
    S_AWVALID = 1; S_AWADDR = 32'h0000_0080; M0_AWREADY = 1; M0_BVALID = 1; S_BREADY = 1;
    #1;
    checks++;
    if ({S_AWREADY, S_WREADY, S_BVALID, M0_AWVALID, M1_AWVALID, M0_WVALID, M1_WVALID,
         M0_BREADY, M1_BREADY} !== 9'b0) begin
      errors++;
      $display("FAIL reset_mid_gate got %b expected 0", {S_AWREADY, S_WREADY, S_BVALID,
               M0_AWVALID, M1_AWVALID, M0_WVALID, M1_WVALID, M0_BREADY, M1_BREADY});
    end
    tick();
    ARESET = 0; S_AWVALID = 0; M0_BVALID = 0;
    #1;
    checks++;
    if (dbg_out_cnt !== 3'd0 || dbg_w_pend !== 3'd0 || S_WREADY !== 1'b0 || M0_WVALID !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_clear got out=%0d wp=%0d wready=%b m0_wvalid=%b", dbg_out_cnt,
               dbg_w_pend, S_WREADY, M0_WVALID);
    end
    idle_inputs();
    exp_q.delete();
    w_idx = 0;
    tick();
    do_aw(32'h1000_0010, 0);
    do_w_burst(4, 0);
    do_b(0);
  endtask

  task automatic test_unmatched();
    do_reset();
    do_aw(32'h8000_0000, 0);
    do_w_burst(2, 0);
    do_b(0);
    checks++;
    if (dbg_out_cnt !== 3'd0) begin
      errors++;
      $display("FAIL unmatched_cnt got %0d expected 0", dbg_out_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int step = 0; step < 250; step++) begin
      int act;
      act = $urandom_range(0, 2);
      checks++;
      if (dbg_out_cnt !== 3'(exp_q.size()) || dbg_w_pend !== 3'(exp_q.size() - w_idx)) begin
        errors++;
        $display("FAIL random_counts step=%0d got out=%0d wp=%0d expected %0d %0d", step,
                 dbg_out_cnt, dbg_w_pend, exp_q.size(), exp_q.size() - w_idx);
      end
      if (act == 0 && exp_q.size() < DEPTH) do_aw(rand_addr(), 1);
      else if (act == 1 && w_idx < exp_q.size()) do_w_burst($urandom_range(1, 4), 1);
      else if (w_idx > 0) do_b(1);
      else tick();
    end
    drain();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    w_idx = 0;
    ARESET = 1;
    idle_inputs();
    test_reset();
    test_single_m1();
    test_order();
    test_early_w();
    test_back_to_back();
    test_full();
    test_reset_mid();
    test_unmatched();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
